// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB + PC).
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             en_vps1,
  output logic             en_vps2,
  output logic             en_vps3,
  output logic             en_vps4,
  output logic             clear_vps1,
  output logic             clear_vps2,
  output logic             clear_vps3,
  output logic             clear_vps4,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned NUM_VPS = 4;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MDU_WAIT = 2'd1,
    S_HALT     = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [NUM_VPS-1:0] en_v;
  logic [NUM_VPS-1:0] clr_v;
  logic               load_use;
  logic               mem_wait;
  logic               mdu_stall;
  logic               stall_evt;
  logic               flush_evt;

  // Hazard detection terms
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));
  assign mem_wait = mem_req && !mem_ready;
  assign mdu_stall = ((state_q == S_RUN) && ex_mdu_start && !mdu_done) ||
                     ((state_q == S_MDU_WAIT) && !mdu_done);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and control outputs, first matching rule wins
  always_comb begin
    state_d     = state_q;
    en_v        = '1;
    clr_v       = '1;
    pc_en       = 1'b1;
    pc_redirect = 1'b0;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;

    if (rst) begin
      clr_v   = '0;
      pc_en   = 1'b0;
      state_d = S_RUN;
    end else if (!en) begin
      en_v  = '0;
      pc_en = 1'b0;
    end else if (state_q == S_HALT) begin
      en_v  = '0;
      pc_en = 1'b0;
    end else if (mem_wait) begin
      // A pending MDU wait stays pending across the memory stall
      en_v      = '0;
      pc_en     = 1'b0;
      stall_evt = 1'b1;
    end else if (wb_halt) begin
      state_d = S_HALT;
    end else if (mdu_stall) begin
      pc_en     = 1'b0;
      en_v[0]   = 1'b0;
      en_v[1]   = 1'b0;
      clr_v[2]  = 1'b0;
      state_d   = S_MDU_WAIT;
      stall_evt = 1'b1;
    end else if (state_q == S_MDU_WAIT) begin
      state_d = S_RUN;
    end else if (ex_redirect) begin
      // Squashes the ID instruction, so a coincident load-use stall is moot
      clr_v[0]    = 1'b0;
      clr_v[1]    = 1'b0;
      pc_redirect = 1'b1;
      flush_evt   = 1'b1;
    end else if (load_use) begin
      pc_en     = 1'b0;
      en_v[0]   = 1'b0;
      clr_v[1]  = 1'b0;
      stall_evt = 1'b1;
    end
  end

  assign en_vps1    = en_v[0];
  assign en_vps2    = en_v[1];
  assign en_vps3    = en_v[2];
  assign en_vps4    = en_v[3];
  assign clear_vps1 = clr_v[0];
  assign clear_vps2 = clr_v[1];
  assign clear_vps3 = clr_v[2];
  assign clear_vps4 = clr_v[3];
  assign halted     = (state_q == S_HALT);

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Free-running wrap-around perf counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (flush_evt) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  logic unused_evt;
  assign unused_evt   = stall_evt ^ flush_evt;
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV32 pipeline. It drives the `en_vpsN` / `clear_vpsN` controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC enable. Its inputs are ID/EX hazard information, EX redirects, multi-cycle MDU status, the data-memory wait handshake and WB halt. It replaces the constant enable/clear tie-offs at the top level.

## Interface
Parameters:
- `REG_W`, 5: register-index width.
- `CNT_W`, 32: performance-counter width.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  global core enable; 0 freezes everything.
- `id_rs1`, `id_rs2`  in  REG_W  source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1  ID instruction actually reads rs1/rs2.
- `ex_rd`  in  REG_W  destination of the instruction in EX.
- `ex_mem_read`  in  1  EX instruction is a load.
- `ex_redirect`  in  1  EX resolved a taken branch/jump.
- `ex_mdu_start`  in  1  EX holds a multi-cycle mul/div.
- `mdu_done`  in  1  MDU result valid this cycle.
- `mem_req`, `mem_ready`  in  1  data-memory request in MEM and its ready.
- `wb_halt`  in  1  ecall/ebreak retiring in WB.
- `pc_en`  out  1  PC register update enable.
- `pc_redirect`  out  1  PC selects the EX target.
- `en_vps1`..`en_vps4`  out  1 each  pipeline-register load enables.
- `clear_vps1`..`clear_vps4`  out  1 each  active-low flush: 0 loads a bubble at the next edge (takes effect only when the matching `en_vpsN`=1).
- `halted`  out  1  core halted.
- `stall_cycles`, `flush_count`  out  CNT_W  performance counters.

## Operation
- State FSM: RUN, MDU_WAIT, HALT.
- All control outputs are combinational from the current state and inputs. The defaults are all `en_vpsN`=1, all `clear_vpsN`=1, `pc_en`=1 and `pc_redirect`=0.
- Priority, highest first. The first matching rule sets the outputs.
  1. `rst`: all `en_vpsN`=1, all `clear_vpsN`=0, `pc_en`=0. The next state is RUN.
  2. `en`=0: all `en_vpsN`=0, `pc_en`=0. State and counters hold.
  3. HALT: all `en_vpsN`=0, `pc_en`=0, `halted`=1. This state is left only by `rst`.
  4. Memory wait (`mem_req & ~mem_ready`): all `en_vpsN`=0, `pc_en`=0. The state holds; an MDU_WAIT remains pending.
  5. `wb_halt`: next state is HALT. The current cycle's outputs are the defaults, so WB retires.
  6. MDU stall (RUN with `ex_mdu_start & ~mdu_done`, or MDU_WAIT with `~mdu_done`): `pc_en`=0, `en_vps1`=`en_vps2`=0, `clear_vps3`=0 (bubble into EX/MEM). Next state is MDU_WAIT.
     - MDU_WAIT with `mdu_done`: outputs are the defaults, next state is RUN.
     - A start that completes in the same cycle (`ex_mdu_start & mdu_done` in RUN) causes no stall.
  7. `ex_redirect`: `clear_vps1`=`clear_vps2`=0 and `pc_redirect`=1. This overrides a load-use stall in the same cycle, because the ID instruction is squashed anyway.
  8. Load-use: `ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))` gives `pc_en`=0, `en_vps1`=0, `clear_vps2`=0. This inserts exactly one bubble.
- `ex_redirect` and `ex_mdu_start` are never asserted together by the datapath. If both are asserted, the MDU rule wins and the redirect is re-presented later.
- Counters:
  - `stall_cycles` increments on every cycle where rule 4, 6 or 8 applies with `en`=1.
  - `flush_count` increments on each cycle where rule 7 applies.
  - Both wrap modulo 2^CNT_W.

## Timing
- Control outputs have zero-cycle latency: they act at the same edge as the hazard.
- Load-use costs exactly 1 cycle. A redirect costs 2 squashed instructions. An MDU op of N cycles stalls the front end for N-1 cycles.
- Reset values (sampled after the first `rst` edge): state RUN, `halted`=0, counters 0.
- A reset asserted mid-MDU_WAIT or mid-HALT returns to RUN at the next edge.
- `rst` overrides `en`=0.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: `stall_cycles` and `flush_count` are implemented as specified.
- Undefined: the counter registers are omitted, both outputs are tied to 0, and all other behaviour is identical.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5, `id_use_rs1`=1. Required: one cycle of `pc_en`=0, `en_vps1`=0, `clear_vps2`=0, then defaults. `stall_cycles` goes +1. The same stimulus with `ex_rd`=0 gives no stall.
- Redirect plus load-use in the same cycle: `clear_vps1`=`clear_vps2`=0, `pc_redirect`=1, `pc_en`=1. `flush_count` goes +1 and `stall_cycles` is unchanged.
- MDU: `ex_mdu_start` with `mdu_done` arriving 4 cycles later. Required: 4 cycles of `en_vps1`=`en_vps2`=0 and `clear_vps3`=0, then RUN with defaults in the `mdu_done` cycle. `stall_cycles`=4.
- Memory wait inside MDU_WAIT: `mem_ready`=0 for 2 cycles gives all `en_vpsN`=0. The state stays MDU_WAIT, and a later `mdu_done` resumes normally.
- `wb_halt` pulse: the next cycle has `halted`=1 and all enables 0, and stays that way for 10+ cycles. Then `rst`=1 for one edge gives `halted`=0, state RUN and counters 0.
- `en`=0 during a load-use hazard: all enables 0 and counters frozen. Restoring `en`=1 performs exactly one load-use stall.
